// File: rtl/ser_pkg.sv
// Shared serial-link definitions used by both the serializer and deserializer paths.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package ser_pkg;

  localparam int   FRAME_LEN = 11;
  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Even parity: the parity bit equals the XOR of all data bits.
  function automatic logic even_par(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// N-entry first-word-fall-through byte FIFO (circular buffer).
// Latency: a pushed byte is visible on dout the cycle after the push edge.
// Backpressure: push while full is ignored unless a pop happens on the same edge.
module byte_fifo
  import ser_pkg::*;
#(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_BITS-1:0] din,
  output logic [DATA_BITS-1:0] dout,
  output logic [W-1:0]         count,
  output logic                 empty,
  output logic                 full
);

  localparam logic [W-1:0] LAST  = W'(N - 1);
  localparam logic [W-1:0] DEPTH = W'(N);
  localparam logic [W-1:0] ONE   = W'(1);

  logic [DATA_BITS-1:0] mem [0:N-1];
  logic [W-1:0]         wr_ptr;
  logic [W-1:0]         rd_ptr;
  logic                 wr_en;
  logic                 rd_en;

  function automatic logic [W-1:0] ptr_inc(input logic [W-1:0] p);
    return (p == LAST) ? '0 : p + ONE;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == DEPTH);
  // A pop frees the slot the simultaneous push needs, so push+pop is legal when full.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = empty ? '0 : mem[rd_ptr];

  // Storage array: written only on accepted pushes.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/deserializer_block.sv
// Serial-frame receiver: start, 8 data bits LSB first, even parity, stop -> bytes into a FWFT FIFO.
// Latency: byte visible on data_o the cycle after the stop-bit edge (11 sampled bits per frame).
// Backpressure: none on the line; a good byte arriving while full (no pop) is dropped with overflow_o.
// Build option: define DESER_PARITY_CHECK_EN to reject frames whose parity bit mismatches.
module deserializer_block
  import ser_pkg::*;
#(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic                 data_i,
  input  logic                 rd_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 busy_o,
  output logic [W-1:0]         count_o,
  output logic                 frame_err_o,
  output logic                 overflow_o
);

  state_t               state_q, state_n;
  logic [2:0]           bitcnt_q, bitcnt_n;
  logic [DATA_BITS-1:0] shreg_q, shreg_n;
  logic                 push;
  logic                 err_n;
  logic                 ovf_n;
  logic                 par_ok;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 pop_eff;

`ifdef DESER_PARITY_CHECK_EN
  logic par_q, par_n;
  assign par_ok = (even_par(shreg_q) == par_q);

  // Captured parity bit, compared against the received data in STOP.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) par_q <= 1'b0;
    else          par_q <= par_n;
  end
`else
  // Parity bit is still consumed as a frame slot but never judged.
  assign par_ok = 1'b1;
`endif

  assign pop_eff = rd_i && !fifo_empty;
  // Overflow only ever arises from a good frame, so it cannot coincide with frame_err.
  assign ovf_n   = push && fifo_full && !pop_eff;

  // Frame state register, bit counter and data shift register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      bitcnt_q <= 3'd0;
      shreg_q  <= '0;
    end else begin
      state_q  <= state_n;
      bitcnt_q <= bitcnt_n;
      shreg_q  <= shreg_n;
    end
  end

  // Next-state decode: walk the frame, abort on en_i drop, judge the frame at STOP.
  always_comb begin
    state_n  = state_q;
    bitcnt_n = bitcnt_q;
    shreg_n  = shreg_q;
    push     = 1'b0;
    err_n    = 1'b0;
`ifdef DESER_PARITY_CHECK_EN
    par_n    = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (en_i && (data_i == START_LVL)) begin
          state_n  = DATA;
          bitcnt_n = 3'd0;
        end
      end
      DATA: begin
        if (!en_i) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else begin
          shreg_n[bitcnt_q] = data_i;
          bitcnt_n          = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_n = PARITY;
        end
      end
      PARITY: begin
        if (!en_i) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else begin
`ifdef DESER_PARITY_CHECK_EN
          par_n   = data_i;
`endif
          state_n = STOP;
        end
      end
      STOP: begin
        state_n = IDLE;
        if (en_i && (data_i == STOP_LVL) && par_ok) push  = 1'b1;
        else                                        err_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Error and overflow pulses, aligned with the cycle the byte would appear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      frame_err_o <= err_n;
      overflow_o  <= ovf_n;
    end
  end

  byte_fifo #(
    .N(N),
    .W(W)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .push   (push),
    .pop    (rd_i),
    .din    (shreg_q),
    .dout   (data_o),
    .count  (count_o),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  assign valid_o = !fifo_empty;
  assign busy_o  = fifo_full;

endmodule

// File: tb/tb_deserializer_block.sv
// Bench for deserializer_block: directed frames with literal expectations plus randomized traffic.
// A frame-level model (collected bits + byte queue) predicts every output on every cycle.
// Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
module tb_deserializer_block;

  localparam int N = 5;
  localparam int W = 3;

  logic         clk_i   = 1'b0;
  logic         rst_n_i = 1'b0;
  logic         en_i    = 1'b0;
  logic         data_i  = 1'b1;
  logic         rd_i    = 1'b0;
  logic [7:0]   data_o;
  logic         valid_o;
  logic         busy_o;
  logic [W-1:0] count_o;
  logic         frame_err_o;
  logic         overflow_o;

  int tests    = 0;
  int fails    = 0;
  int ovf_seen = 0;
  bit rd_rand  = 1'b0;

  always #5 clk_i = ~clk_i;

  deserializer_block #(.N(N), .W(W)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .en_i       (en_i),
    .data_i     (data_i),
    .rd_i       (rd_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .busy_o     (busy_o),
    .count_o    (count_o),
    .frame_err_o(frame_err_o),
    .overflow_o (overflow_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: bits of the frame in progress and the queue of stored bytes.
  logic [7:0]  mq[$];
  int          nbits = 0;
  logic [10:0] fbits;
  bit          m_err = 1'b0;
  bit          m_ovf = 1'b0;

  always @(posedge clk_i or negedge rst_n_i) begin
    bit         mpush, mpop, par_bad;
    logic [7:0] b;
    if (!rst_n_i) begin
      mq.delete();
      nbits = 0;
      m_err = 1'b0;
      m_ovf = 1'b0;
    end else begin
      m_err = 1'b0;
      m_ovf = 1'b0;
      mpush = 1'b0;
      b     = 8'h00;
      mpop  = rd_i && (mq.size() > 0);
      if (nbits == 0) begin
        if (en_i && !data_i) begin
          fbits = '0;
          nbits = 1;
        end
      end else if (!en_i) begin
        m_err = 1'b1;
        nbits = 0;
      end else begin
        fbits[nbits] = data_i;
        nbits++;
        if (nbits == 11) begin
          nbits = 0;
          b     = fbits[8:1];
`ifdef DESER_PARITY_CHECK_EN
          par_bad = ((^b) != fbits[9]);
`else
          par_bad = 1'b0;
`endif
          if (fbits[10] !== 1'b1 || par_bad) m_err = 1'b1;
          else                                mpush = 1'b1;
        end
      end
      if (mpop) void'(mq.pop_front());
      if (mpush) begin
        if (mq.size() < N) mq.push_back(b);
        else               m_ovf = 1'b1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_i) begin
    logic [14:0] act, exp;
    act = {data_o, valid_o, busy_o, count_o, frame_err_o, overflow_o};
    exp = {(mq.size() > 0) ? mq[0] : 8'h00, 1'(mq.size() > 0), 1'(mq.size() == N),
           3'(mq.size()), m_err, m_ovf};
    chk("cycle {data,valid,busy,count,err,ovf}", {17'd0, act}, {17'd0, exp});
    if (overflow_o) ovf_seen++;
  end

  task automatic tick(input logic en, input logic d, input logic rd);
    en_i   = en;
    data_i = d;
    rd_i   = rd_rand ? 1'($urandom_range(0, 1)) : rd;
    @(posedge clk_i);
    #1;
  endtask

  // Drive one frame; drop_at = bit slot where en_i falls instead (-1 for none).
  task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                      input int drop_at, input bit rd_stop);
    logic [10:0] f;
    f = {~bad_stop, (^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (i == drop_at) begin
        tick(1'b0, 1'b1, 1'b0);
        return;
      end
      tick(1'b1, f[i], rd_stop && (i == 10));
    end
  endtask

  initial begin
    int o0;
    int r;
    logic [7:0] rb;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_data", data_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_pulses", {frame_err_o, overflow_o, busy_o}, 0);
    rst_n_i = 1'b1;
    repeat (2) tick(1'b1, 1'b1, 1'b0);

    // Single byte 0xA5
    send(8'hA5, 1'b0, 1'b0, -1, 1'b0);
    chk("a5_data", data_o, 8'hA5);
    chk("a5_valid", valid_o, 1);
    chk("a5_count", count_o, 1);
    chk("a5_pulses", {frame_err_o, overflow_o}, 0);
    tick(1'b1, 1'b1, 1'b1);
    chk("a5_popped", count_o, 0);

    // Back-to-back 0x01..0x06 with no reads
    o0 = ovf_seen;
    for (int i = 1; i <= 6; i++) begin
      send(8'(i), 1'b0, 1'b0, -1, 1'b0);
      if (i == 5) chk("b2b_busy", busy_o, 1);
      if (i == 6) chk("b2b_ovf_pulse", overflow_o, 1);
    end
    tick(1'b1, 1'b1, 1'b0);
    chk("b2b_ovf_once", ovf_seen - o0, 1);
    chk("b2b_count", count_o, 5);
    for (int i = 1; i <= 5; i++) begin
      chk("b2b_pop_data", data_o, i);
      tick(1'b1, 1'b1, 1'b1);
    end
    chk("b2b_drained", valid_o, 0);

    // Bad stop bit then a good frame
    send(8'h3C, 1'b0, 1'b1, -1, 1'b0);
    chk("stop_err", frame_err_o, 1);
    chk("stop_count", count_o, 0);
    send(8'h7E, 1'b0, 1'b0, -1, 1'b0);
    chk("after_err_data", data_o, 8'h7E);
    chk("after_err_err", frame_err_o, 0);
    tick(1'b1, 1'b1, 1'b1);

    // Wrong parity on 0x80
    send(8'h80, 1'b1, 1'b0, -1, 1'b0);
`ifdef DESER_PARITY_CHECK_EN
    chk("par_err", frame_err_o, 1);
    chk("par_count", count_o, 0);
`else
    chk("par_ignored_data", data_o, 8'h80);
    chk("par_ignored_err", frame_err_o, 0);
`endif
    repeat (2) tick(1'b1, 1'b1, 1'b1);

    // en_i dropped after d3, then push+pop while full
    send(8'h9A, 1'b0, 1'b0, 5, 1'b0);
    chk("drop_err", frame_err_o, 1);
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 1'b0, 1'b0, -1, 1'b0);
    chk("full_busy", busy_o, 1);
    send(8'h55, 1'b0, 1'b0, -1, 1'b1);
    chk("full_pushpop_count", count_o, 5);
    chk("full_pushpop_ovf", overflow_o, 0);
    chk("full_pushpop_head", data_o, 8'h11);

    // Asynchronous reset mid-frame with 3 bytes queued
    repeat (5) tick(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send(8'h20 + 8'(i), 1'b0, 1'b0, -1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    #2 rst_n_i = 1'b0;
    #1;
    chk("arst_data", data_o, 0);
    chk("arst_valid_count", {valid_o, count_o}, 0);
    repeat (2) tick(1'b1, 1'b1, 1'b0);
    rst_n_i = 1'b1;
    send(8'hC3, 1'b0, 1'b0, -1, 1'b0);
    chk("post_rst_data", data_o, 8'hC3);
    chk("post_rst_count", count_o, 1);

    // Randomized traffic with random reads
    rd_rand = 1'b1;
    repeat (200) begin
      r  = $urandom_range(0, 99);
      rb = 8'($urandom);
      if (r < 8)       send(rb, 1'b0, 1'b1, -1, 1'b0);
      else if (r < 16) send(rb, 1'b1, 1'b0, -1, 1'b0);
      else if (r < 22) send(rb, 1'b0, 1'b0, $urandom_range(1, 10), 1'b0);
      else             send(rb, 1'b0, 1'b0, -1, 1'b0);
      repeat ($urandom_range(0, 2)) tick(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end
    rd_rand = 1'b0;
    repeat (3) tick(1'b1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/deserializer_block.md
Name: deserializer_block

Overview:
- Receive side of the team's serial link: converts the 11-bit serial frames produced by the parallel-to-serial path back into bytes.
- Samples one bit per clock while the link-valid strobe is high, checks the frame and pushes good bytes into an N-byte FIFO.
- The FIFO is read by the downstream parallel consumer with a read strobe; data is first-word fall-through.

Parameters:
- N, default 5: FIFO depth in bytes; legal range 1..7.
- W, default 3: FIFO count width; must satisfy 2**W > N.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- en_i  in  1  serial data valid; one bit is sampled per rising edge while high.
- data_i  in  1  serial line.
- rd_i  in  1  pop strobe; ignored when valid_o=0.
- data_o  out  8  FIFO head byte.
- valid_o  out  1  FIFO non-empty.
- busy_o  out  1  FIFO full (count==N).
- count_o  out  W  bytes held.
- frame_err_o  out  1  one-cycle pulse: bad stop bit, bad parity or en_i dropped mid-frame.
- overflow_o  out  1  one-cycle pulse: good byte dropped because the FIFO was full.

Behaviour:
- Interface (already decided): one clock clk_i; reset rst_n_i is asynchronous, active-low.
- Reset (rst_n_i=0, async): FSM=IDLE; FIFO empty; shift register=0. Outputs: data_o=0, valid_o=0, busy_o=0, count_o=0, frame_err_o=0, overflow_o=0. A reset mid-frame discards the partial frame.
- Frame, LSB first: start(0), d0..d7, parity, stop(1). Parity is even: parity bit = XOR(d7..d0).
- FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE. Bit counter is 3 bits.
  - IDLE: on en_i=1 and data_i=0, go to DATA with bitcnt=0. en_i=1 with data_i=1 is idle line; stay in IDLE.
  - DATA: on each en_i=1 edge, shift data_i into bit[bitcnt] and increment bitcnt. After bitcnt==7, go to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: if data_i=1 and parity is OK, push the byte. Otherwise pulse frame_err_o and drop the byte. Always return to IDLE.
  - A new start bit may be sampled on the very next edge after STOP; back-to-back frames need no gap.
- en_i=0 in any non-IDLE state: abort to IDLE, pulse frame_err_o, drop the partial byte.
- Latency: start sampled at edge 0, stop at edge 10. The byte is visible on data_o with valid_o=1 after edge 10.
- FIFO:
  - Circular buffer with rd/wr pointers wrapping at N-1 -> 0.
  - data_o = mem[rd_ptr] when non-empty, else 0.
  - Pop on the edge where rd_i=1 and valid_o=1.
- Simultaneous push and pop: always accepted, count unchanged, including when full.
- Push when full with no pop: byte dropped; overflow_o pulses; FIFO contents and count unchanged.
- Push when empty: no bypass; the byte appears the cycle after the STOP edge.
- frame_err_o and overflow_o never assert in the same cycle, because overflow only applies to good frames.

Optional Feature:
- Macro DESER_PARITY_CHECK_EN.
- Defined: a parity mismatch in STOP rejects the byte and pulses frame_err_o.
- Undefined: the parity bit is still consumed (the frame stays 11 bits) but ignored; only the stop bit and en_i drop cause errors.

Decomposition:
- Shared package (header) ser_pkg holds:
  - FRAME_LEN=11
  - DATA_BITS=8
  - state encodings IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3
  - START_LVL=1'b0, STOP_LVL=1'b1
- The serializer path includes the same header.
- One sub-module is natural: byte_fifo, parameterised by N and W. Ports: push, pop, din, dout, count, empty, full.
- The FSM and error logic stay in deserializer_block.

Test Plan:
- Byte 0xA5: en_i=1; serial 0,1,0,1,0,0,1,0,1, parity 0, stop 1 -> data_o=0xA5 and valid_o=1 after edge 10; count_o=1; no error pulses.
- Back-to-back 0x01,0x02,...,0x06 with no gaps and rd_i=0 (N=5) -> busy_o=1 after the 5th byte; overflow_o pulses once on the 6th byte's STOP edge; pops return 0x01..0x05.
- Frame 0x3C with stop bit=0 -> frame_err_o pulses once; count_o unchanged; the next good frame 0x7E is received normally.
- Frame 0x80 with parity bit=0 (wrong; expected 1) -> with DESER_PARITY_CHECK_EN, frame_err_o pulses and nothing is stored; without it, 0x80 is stored.
- en_i dropped after d3 -> frame_err_o pulses; FSM in IDLE. With the FIFO full, rd_i=1 on the push edge of the next good byte 0x55 -> accepted; count_o stays 5; no overflow.
- rst_n_i pulled low mid-frame with 3 bytes queued -> all outputs 0 immediately (asynchronous); after release, frame 0xC3 -> data_o=0xC3, count_o=1.
